byte_receiver: RTL

- Serial-to-parallel capture block for the JTAG data path.
- Samples one TDI bit per rising clk edge while enable is high, MSB first, and assembles a WIDTH-bit word. This is the mirror of the TDO-side transmitter, which drives its word MSB first on falling edges.
- Presents the completed word with a one-cycle valid pulse.
- Flags short (aborted) and overlong (overflow) shift sequences so the TAP/DR logic can reject bad frames.

---
 rtl/byte_receiver.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/byte_receiver.sv
// byte_receiver: serial-to-parallel capture for the JTAG TDI data path.
// Samples one bit per posedge clk while enable is high, MSB first, and
// presents the assembled WIDTH-bit word with a one-cycle valid pulse.
// Short frames raise a one-cycle aborted pulse; extra enabled edges after a
// complete word raise overflow until enable drops.
module byte_receiver #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [5:0]       bit_count,
  output logic             aborted,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);
  localparam logic [5:0] FULL_CNT = 6'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] out_next;
  logic [5:0]       count_next;
  logic             valid_next;
  logic             aborted_next;
  logic             overflow_next;

  assign shifted = {shreg[WIDTH-2:0], in};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: enable defines frame boundaries
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = SHIFT;
      SHIFT: begin
        if (!enable)                    state_next = IDLE;
        else if (bit_count == LAST_CNT) state_next = FULL;
      end
      FULL:    if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs
  // (outputs are computed here and registered below so nothing is combinational from in/enable)
  always_comb begin
    shreg_next    = shreg;
    out_next      = out;
    count_next    = bit_count;
    valid_next    = 1'b0;
    aborted_next  = 1'b0;
    overflow_next = overflow;
    case (state)
      IDLE: begin
        if (enable) begin
          shreg_next = shifted;
          count_next = 6'd1;
        end
      end
      SHIFT: begin
        if (enable) begin
          shreg_next = shifted;
          count_next = bit_count + 6'd1;
          if (bit_count == LAST_CNT) begin
            out_next   = shifted;
            valid_next = 1'b1;
          end
        end else begin
          aborted_next = 1'b1;
          shreg_next   = '0;
          count_next   = '0;
        end
      end
      FULL: begin
        if (enable) begin
          overflow_next = 1'b1;
        end else begin
          shreg_next    = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      default: begin
        shreg_next    = '0;
        count_next    = '0;
        overflow_next = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      out       <= '0;
      bit_count <= '0;
      valid     <= 1'b0;
      aborted   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      shreg     <= shreg_next;
      out       <= out_next;
      bit_count <= count_next;
      valid     <= valid_next;
      aborted   <= aborted_next;
      overflow  <= overflow_next;
    end
  end

`ifdef FORMAL
  // Structural invariants of the capture state
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_count_range: assert (bit_count <= FULL_CNT);
      a_valid_count: assert (!valid || bit_count == FULL_CNT);
      a_pulse_excl:  assert (!(valid && aborted));
      a_ovf_full:    assert (!overflow || state == FULL);
    end
  end
`endif

endmodule
